// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : instruction-fetch stage, one outstanding bus read, redirect/drop
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] PC_RESET = 64'h0000_0000_8000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic            ireq_valid,
   output logic [XLEN-1:0] ireq_addr,
   input  logic            ireq_ready,
   input  logic            iresp_valid,
   input  logic [31:0]     iresp_data,
   output logic            fetch_valid,
   output logic [XLEN-1:0] fetch_pc,
   output logic [31:0]     fetch_instr,
   output logic            fetch_misalign
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RESP = 2'd1,
      WAIT_DROP = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            halt_q, halt_d;
   logic            fetch_valid_q, fetch_valid_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [31:0]     fetch_instr_q, fetch_instr_d;
   logic            fetch_misalign_q, fetch_misalign_d;

   logic slot_free;
   logic consume;
   logic pc_aligned;

   always_comb begin
      slot_free  = ~fetch_valid_q | ~stall;
      consume    = fetch_valid_q & ~stall;
      pc_aligned = (pc_q[1:0] == 2'b00);

      state_d          = state_q;
      pc_d             = pc_q;
      halt_d           = halt_q;
      fetch_valid_d    = fetch_valid_q & ~consume;
      fetch_pc_d       = fetch_pc_q;
      fetch_instr_d    = fetch_instr_q;
      fetch_misalign_d = fetch_misalign_q;
      ireq_valid       = 1'b0;

      if (redirect_valid) begin
         // An in-flight request becomes stale; wait for its response unless it lands now.
         pc_d          = redirect_pc;
         fetch_valid_d = 1'b0;
         halt_d        = 1'b0;
         state_d       = (state_q == IDLE || iresp_valid) ? IDLE : WAIT_DROP;
      end else begin
         case (state_q)
            IDLE: begin
               if (slot_free) begin
                  if (pc_aligned) begin
                     ireq_valid = ~reset;
                     if (ireq_ready) state_d = WAIT_RESP;
                  end else if (!halt_q) begin
                     // Misaligned target reports a fault in the slot and halts fetch.
                     fetch_valid_d    = 1'b1;
                     fetch_pc_d       = pc_q;
                     fetch_instr_d    = 32'h0;
                     fetch_misalign_d = 1'b1;
                     halt_d           = 1'b1;
                  end
               end
            end
            WAIT_RESP: begin
               if (iresp_valid) begin
                  fetch_valid_d    = 1'b1;
                  fetch_pc_d       = pc_q;
                  fetch_instr_d    = iresp_data;
                  fetch_misalign_d = 1'b0;
                  pc_d             = pc_q + PC_STEP;
                  state_d          = IDLE;
               end
            end
            WAIT_DROP: begin
               if (iresp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         pc_q             <= PC_RESET;
         halt_q           <= 1'b0;
         fetch_valid_q    <= 1'b0;
         fetch_pc_q       <= '0;
         fetch_instr_q    <= 32'h0;
         fetch_misalign_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         halt_q           <= halt_d;
         fetch_valid_q    <= fetch_valid_d;
         fetch_pc_q       <= fetch_pc_d;
         fetch_instr_q    <= fetch_instr_d;
         fetch_misalign_q <= fetch_misalign_d;
      end
   end

   assign ireq_addr      = pc_q;
   assign fetch_valid    = fetch_valid_q;
   assign fetch_pc       = fetch_pc_q;
   assign fetch_instr    = fetch_instr_q;
   assign fetch_misalign = fetch_misalign_q;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of decode.
- Owns the PC and issues one-outstanding-request reads on the instruction bus.
- Captures the returned 32-bit instruction with its PC into an output slot; that slot is what the F→D pipeline register forwards to decode as raw_instr/pc.
- Applies redirects (branch/jump/jr/mret target already selected by pcselect) and discards in-flight responses made stale by a redirect.

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, PC loaded on reset.
- XLEN, 64, PC/address width (word_t).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- redirect_valid  input  1  take redirect_pc this cycle (from pcselect)
- redirect_pc  input  XLEN  redirect target
- stall  input  1  decode not accepting; output slot must hold
- ireq_valid  output  1  instruction read request
- ireq_addr  output  XLEN  request address (= pc)
- ireq_ready  input  1  bus accepts request this cycle
- iresp_valid  input  1  read data returned (exactly one per accepted request)
- iresp_data  input  32  instruction word
- fetch_valid  output  1  output slot holds an instruction
- fetch_pc  output  XLEN  PC of slot instruction
- fetch_instr  output  32  raw instruction
- fetch_misalign  output  1  slot entry is an instruction-address-misaligned fault (pc[1:0]≠0), no bus access made

Behaviour:
- Single clock clk, synchronous active-high reset.
- Reset values:
  - pc=PC_RESET; state=IDLE.
  - fetch_valid=0, fetch_pc=0, fetch_instr=0, fetch_misalign=0.
  - ireq_valid=0 in the reset cycle.
- Slot state:
  - slot_free = ~fetch_valid | ~stall.
  - consume = fetch_valid & ~stall.
- States: IDLE, WAIT_RESP, WAIT_DROP.
- IDLE:
  - ireq_valid = slot_free & ~redirect_valid & (pc[1:0]==0); ireq_addr=pc (combinational).
  - Handshake completes when ireq_valid & ireq_ready → WAIT_RESP. Otherwise stay, and the request is re-presented each cycle.
  - Misaligned pc with slot_free & ~redirect_valid: load slot next edge with fetch_valid=1, fetch_misalign=1, fetch_pc=pc, fetch_instr=0. pc holds. Further fetch halts until a redirect.
- WAIT_RESP:
  - ireq_valid=0.
  - On iresp_valid: slot loads {pc, iresp_data, misalign=0}, fetch_valid=1; pc<=pc+4 (mod 2^XLEN); → IDLE.
- WAIT_DROP:
  - ireq_valid=0.
  - On iresp_valid: data discarded → IDLE. pc unchanged (already holds the redirect target).
- Redirect (highest priority, any state, regardless of stall):
  - pc<=redirect_pc; fetch_valid<=0 next edge.
  - IDLE → IDLE: no request issued that cycle.
  - WAIT_RESP without iresp_valid that cycle → WAIT_DROP.
  - WAIT_RESP with iresp_valid same cycle → response dropped, → IDLE.
  - WAIT_DROP without iresp_valid → stay; pc updated to the newest target.
  - WAIT_DROP with iresp_valid → IDLE.
- Output slot:
  - Cleared on consume unless reloaded the same edge.
  - Held unchanged while stall.
  - A response never arrives into an occupied slot: a request issues only when slot_free, and no other load occurs until its response.
- Contract: pcselect/hazard deasserts redirect_valid while decode is stalled. The block does not check this.
- Throughput: at most one instruction per two cycles (issue cycle + response cycle, with zero-latency bus).
- Reset mid-operation (any state, outstanding request): return to IDLE with reset values. The bus guarantees no response for a request accepted before reset.

Test Plan:
- Reset, then bus always ready with 1-cycle response returning pc-derived data → ireq_addr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; fetch_valid pulses carry matching fetch_pc/fetch_instr; no misalign.
- Response 0x00000013 at pc 0x8000_0010 while stall=1 for 3 cycles → slot holds pc/instr unchanged, ireq_valid=0 for the 3 cycles; first stall=0 cycle consumes and reasserts ireq_valid with addr 0x8000_0014.
- Request accepted at 0x8000_0020, redirect_valid=1 to 0x8000_0100 one cycle before iresp_valid → state WAIT_DROP, response data 0xDEADBEEF never appears on fetch_instr; next ireq_addr=0x8000_0100.
- redirect_valid coincident with iresp_valid in WAIT_RESP → response dropped, fetch_valid=0 next cycle, next ireq_addr=redirect_pc; two back-to-back redirects in WAIT_DROP (0x100 then 0x200) → next fetch from 0x200.
- redirect to 0x8000_0102 → no ireq_valid; fetch_valid=1, fetch_misalign=1, fetch_pc=0x8000_0102; fetch halted until a redirect to 0x8000_0200 resumes requests.
- ireq_ready held 0 for 5 cycles → ireq_valid/addr stable throughout. Then reset asserted while in WAIT_RESP → next cycle pc=PC_RESET, fetch_valid=0, state IDLE.
